// File: rtl/led_sched_pkg.sv
// Shared types and defaults for the LED blink scheduler (FSM state encoding, default tick divider).
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int unsigned TICK_DIV_DEFAULT = 32'd50_000_000;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV clocks; clr restarts the count so the
// first tick lands exactly TICK_DIV cycles after the clearing edge.
module led_tick_gen
    import led_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/led_blink_sched.sv
// LED blink scheduler: start latches on/off/repeat counts and the FSM walks lit/dark phases in ticks.
// Build option LED_BLINK_ACTIVE_LOW_EN drives led=0 for lit and led=1 for dark.
module led_blink_sched
    import led_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] on_ticks,
    input  logic [CNT_W-1:0] off_ticks,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             busy,
    output logic             done,
    output logic             led,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_nxt;
    logic [CNT_W-1:0] blink_cnt, blink_nxt;
    logic [CNT_W-1:0] on_l, off_l, rep_l;
    logic             done_q, done_nxt;
    logic             load;
    logic             tick;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .tick (tick)
    );

    // start and stop are single-cycle strobes sampled on every edge; no handshake back to the requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            blink_cnt <= '0;
            on_l      <= '0;
            off_l     <= '0;
            rep_l     <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            blink_cnt <= blink_nxt;
            done_q    <= done_nxt;
            if (load) begin
                on_l  <= (on_ticks  == '0) ? ONE : on_ticks;
                off_l <= (off_ticks == '0) ? ONE : off_ticks;
                rep_l <= repeat_cnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        blink_nxt = blink_cnt;
        done_nxt  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load      = 1'b1;
                    state_nxt = ON;
                    phase_nxt = '0;
                    blink_nxt = '0;
                end
            end
            ON: begin
                if (stop) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                    blink_nxt = '0;
                end else if (tick) begin
                    if (phase_cnt == on_l - ONE) begin
                        state_nxt = OFF;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase_cnt + ONE;
                    end
                end
            end
            OFF: begin
                if (stop) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                    blink_nxt = '0;
                end else if (tick) begin
                    if (phase_cnt == off_l - ONE) begin
                        phase_nxt = '0;
                        // Repeat count 0 runs forever; the blink counter saturates instead of wrapping.
                        if ((rep_l != '0) && (blink_cnt == rep_l - ONE)) begin
                            state_nxt = IDLE;
                            blink_nxt = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ON;
                            blink_nxt = (blink_cnt == CNT_MAX) ? blink_cnt : blink_cnt + ONE;
                        end
                    end else begin
                        phase_nxt = phase_cnt + ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
                blink_nxt = '0;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign dbg_state = state;

`ifdef LED_BLINK_ACTIVE_LOW_EN
    assign led = (state != ON);
`else
    assign led = (state == ON);
`endif

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched with TICK_DIV=4; cycle k means k rising edges after start was raised.
module tb_led_blink_sched;
    import led_sched_pkg::*;

    localparam int TD = 4;
    localparam int CW = 8;

`ifdef LED_BLINK_ACTIVE_LOW_EN
    localparam logic LIT  = 1'b0;
    localparam logic DARK = 1'b1;
`else
    localparam logic LIT  = 1'b1;
    localparam logic DARK = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] on_ticks;
    logic [CW-1:0] off_ticks;
    logic [CW-1:0] repeat_cnt;
    logic          busy;
    logic          done;
    logic          led;
    state_t        dbg_state;

    int checks;
    int failures;

    led_blink_sched #(.TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .on_ticks   (on_ticks),
        .off_ticks  (off_ticks),
        .repeat_cnt (repeat_cnt),
        .busy       (busy),
        .done       (done),
        .led        (led),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timing: each blink is (on+off)*TD cycles starting at cycle 1; done lands one cycle after the last.
    function automatic void exp_at(input int k, input int on, input int off, input int rep,
                                   output logic e_led, output logic e_busy, output logic e_done);
        int on_e, off_e, len, pos;
        on_e  = (on  == 0) ? 1 : on;
        off_e = (off == 0) ? 1 : off;
        len   = (on_e + off_e) * TD;
        if (rep != 0 && k > rep * len) begin
            e_busy = 1'b0;
            e_led  = DARK;
            e_done = (k == rep * len + 1);
        end else begin
            pos    = (k - 1) % len;
            e_busy = 1'b1;
            e_done = 1'b0;
            e_led  = (pos < on_e * TD) ? LIT : DARK;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises start for one edge; returns positioned in cycle 1.
    task automatic do_start(input int on, input int off, input int rep);
        on_ticks   = CW'(on);
        off_ticks  = CW'(off);
        repeat_cnt = CW'(rep);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        on_ticks = '0; off_ticks = '0; repeat_cnt = '0;
        #2;
        checks++;
        if (led !== DARK || busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: led=%b busy=%b done=%b state=%0d want led=%b busy=0 done=0 state=0",
                     led, busy, done, dbg_state, DARK);
        end
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || led !== DARK) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b led=%b want busy=0 led=%b", busy, led, DARK);
        end
    endtask

    task automatic test_basic();
        logic e_led, e_busy, e_done;
        do_start(2, 1, 2);
        for (int k = 1; k <= 30; k++) begin
            exp_at(k, 2, 1, 2, e_led, e_busy, e_done);
            checks++;
            if (led !== e_led || busy !== e_busy || done !== e_done) begin
                failures++;
                $display("FAIL basic_c%0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                         k, led, busy, done, e_led, e_busy, e_done);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic e_led, e_busy, e_done;
        do_start(2, 1, 2);
        for (int k = 1; k <= 27; k++) begin
            exp_at(k, 2, 1, 2, e_led, e_busy, e_done);
            checks++;
            if (led !== e_led || busy !== e_busy || done !== e_done) begin
                failures++;
                $display("FAIL ignore_start_c%0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                         k, led, busy, done, e_led, e_busy, e_done);
            end
            if (k == 3) begin
                on_ticks = 8'd5; off_ticks = 8'd5; repeat_cnt = 8'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_stop();
        logic e_led, e_busy, e_done;
        do_start(3, 2, 2);
        for (int k = 1; k <= 5; k++) begin
            exp_at(k, 3, 2, 2, e_led, e_busy, e_done);
            checks++;
            if (led !== e_led || busy !== e_busy || done !== e_done) begin
                failures++;
                $display("FAIL stop_pre_c%0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                         k, led, busy, done, e_led, e_busy, e_done);
            end
            if (k == 5) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        checks++;
        if (dbg_state !== IDLE || led !== DARK || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stop_c6: state=%0d led=%b busy=%b done=%b want state=0 led=%b busy=0 done=0",
                     dbg_state, led, busy, done, DARK);
        end
        for (int k = 7; k <= 40; k++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL stop_quiet_c%0d: done=%b busy=%b want done=0 busy=0", k, done, busy);
            end
        end
        step();
    endtask

    task automatic test_repeat_forever();
        logic e_led, e_busy, e_done;
        do_start(1, 1, 0);
        for (int k = 1; k <= 80; k++) begin
            exp_at(k, 1, 1, 0, e_led, e_busy, e_done);
            checks++;
            if (led !== e_led || busy !== e_busy || done !== e_done) begin
                failures++;
                $display("FAIL forever_c%0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                         k, led, busy, done, e_led, e_busy, e_done);
            end
            if (k == 80) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || led !== DARK || done !== 1'b0) begin
            failures++;
            $display("FAIL forever_stop: busy=%b led=%b done=%b want busy=0 led=%b done=0",
                     busy, led, done, DARK);
        end
        step();
    endtask

    task automatic test_start_stop_same();
        on_ticks = 8'd1; off_ticks = 8'd1; repeat_cnt = 8'd1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (busy !== 1'b0 || led !== DARK || done !== 1'b0) begin
                failures++;
                $display("FAIL start_stop_c%0d: busy=%b led=%b done=%b want busy=0 led=%b done=0",
                         k, busy, led, done, DARK);
            end
            step();
        end
    endtask

    task automatic test_clamp();
        logic e_led, e_busy, e_done;
        do_start(0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            exp_at(k, 0, 0, 1, e_led, e_busy, e_done);
            checks++;
            if (led !== e_led || busy !== e_busy || done !== e_done) begin
                failures++;
                $display("FAIL clamp_c%0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                         k, led, busy, done, e_led, e_busy, e_done);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_start(1, 2, 0);
        for (int k = 1; k < 6; k++) step();
        checks++;
        if (led !== DARK || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_off: led=%b busy=%b want led=%b busy=1", led, busy, DARK);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (dbg_state !== IDLE || led !== DARK || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: state=%0d led=%b busy=%b done=%b want state=0 led=%b busy=0 done=0",
                     dbg_state, led, busy, done, DARK);
        end
        step();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (busy !== 1'b0 || led !== DARK || done !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_after_c%0d: busy=%b led=%b done=%b want busy=0 led=%b done=0",
                         k, busy, led, done, DARK);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stop();
        test_repeat_forever();
        test_start_stop_same();
        test_clamp();
        test_reset_mid();
        // Sequence after a mid-run reset must still work normally.
        test_basic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_blink_sched.md
LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per timing tick (range 2..2^32-1).
REQ-002 SHALL have parameter CNT_W, default 8, width of the on/off/repeat count inputs.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a blink sequence.
REQ-006 SHALL have port stop  input  1  abort request, level or pulse.
REQ-007 SHALL have port on_ticks  input  CNT_W  ticks the LED is lit per blink.
REQ-008 SHALL have port off_ticks  input  CNT_W  ticks the LED is dark per blink.
REQ-009 SHALL have port repeat_cnt  input  CNT_W  blinks per sequence; 0 = repeat until stop.
REQ-010 SHALL have port busy  output  1  high while a sequence runs.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.
REQ-012 SHALL have port led  output  1  LED drive.

Function
REQ-013 SHALL implement FSM states IDLE, ON, OFF.
REQ-014 SHALL, in IDLE, accept start by latching on_ticks, off_ticks and repeat_cnt and entering ON on the next edge; busy=1 and led lit from that edge onward.
REQ-015 SHALL ignore start while busy=1; latched values SHALL NOT change mid-sequence.
REQ-016 SHALL clamp latched on_ticks=0 and off_ticks=0 to 1.
REQ-017 SHALL clear the prescaler on start acceptance and emit one tick every TICK_DIV cycles thereafter.
REQ-018 SHALL hold ON for exactly on_ticks*TICK_DIV cycles and OFF for exactly off_ticks*TICK_DIV cycles.
REQ-019 SHALL count one blink at the end of each OFF phase; after the repeat_cnt-th blink, return to IDLE with done=1 for one cycle and busy=0 on the same edge.
REQ-020 SHALL, with repeat_cnt=0, alternate ON/OFF indefinitely and never pulse done.
REQ-021 SHALL, on stop=1 in ON or OFF, enter IDLE on the next edge with led dark, busy=0 and no done pulse.
REQ-022 SHALL give stop priority over start when both are high in the same cycle in IDLE (start discarded).
REQ-023 SHALL keep the phase counter and the blink counter CNT_W bits wide with no wrap-around; the prescaler SHALL be $clog2(TICK_DIV) bits wide.

Reset
REQ-024 SHALL, while rst=0, force state IDLE, all counters to 0, busy=0, done=0, led dark, regardless of clk.
REQ-025 SHALL, on reset asserted mid-sequence, drop the sequence without a done pulse; after release, wait for a new start.

Configuration
REQ-026 SHALL, with macro LED_BLINK_ACTIVE_LOW_EN defined, drive led=0 for lit and led=1 for dark (including during reset).
REQ-027 SHALL, without LED_BLINK_ACTIVE_LOW_EN, drive led=1 for lit and led=0 for dark.

Structure
REQ-028 SHALL take the state enum type and the default TICK_DIV constant from shared package led_sched_pkg.
REQ-029 SHALL place the prescaler in sub-module led_tick_gen (inputs clk, rst, clr; output tick).

Verification (TICK_DIV=4, active-high build unless stated)
REQ-030 SHALL cover start with on=2, off=1, repeat=2 -> led high 8 cycles, low 4, high 8, low 4; done pulse at cycle 25 after start; busy high for cycles 1..24.
REQ-031 SHALL cover stop asserted 5 cycles into ON -> cycle 6: IDLE, led=0, busy=0, done never asserted.
REQ-032 SHALL cover repeat=0, on=1, off=1 -> 10 blinks of 4 high / 4 low, done stays 0 until stop.
REQ-033 SHALL cover start and stop in the same IDLE cycle -> busy stays 0; second start while busy -> ignored, timing unchanged.
REQ-034 SHALL cover on=0, off=0, repeat=1 -> clamped: led high 4 cycles, low 4, done on cycle 9.
REQ-035 SHALL cover rst=0 pulse mid-OFF -> immediate IDLE, led dark; LED_BLINK_ACTIVE_LOW_EN build -> led=1 during reset and dark phases.
